reg_bank_shadow: RTL and testbench
==================================

# reg_bank_shadow

Parametrised, double-buffered register bank with byte-lane write enables and atomic commit. Software-side writes land in a shadow copy; a single `commit` pulse transfers every modified shadow register to the active copy in one cycle, so downstream logic never sees a partially updated configuration. This is the multi-register, multi-width successor of the single 8-bit enable register, used wherever several control words must change together.

## Interface
- `WIDTH`, 32, data width in bits; must be a multiple of 8, ≥ 8.
- `NREGS`, 4, number of registers; ≥ 1, need not be a power of two.
- `RESET_VAL`, 0, WIDTH-bit reset value of every shadow and active register.
- `ADDR_W` (localparam): `max(1, clog2(NREGS))`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  ADDR_W  write register index.
- `wr_data`  in  WIDTH  write data.
- `wr_be`  in  WIDTH/8  byte enables; bit b enables `wr_data[8b+7:8b]`.
- `commit`  in  1  copy all dirty shadow registers to active.
- `discard`  in  1  restore all shadow registers from active.
- `rd_addr`  in  ADDR_W  read register index.
- `rd_sel`  in  1  0 = read active copy, 1 = read shadow copy.
- `rd_data`  out  WIDTH  registered read data.
- `active_flat`  out  NREGS*WIDTH  all active registers, reg i at `[i*WIDTH +: WIDTH]`.
- `dirty_any`  out  1  OR of per-register dirty bits.
- `commit_done`  out  1  one-cycle pulse after a commit.
- `wr_err`  out  1  one-cycle pulse for a write to `wr_addr ≥ NREGS`.

## Operation
- State: `shadow[i]`, `active[i]`, `dirty[i]` for i in 0..NREGS-1.
- Reset (`rst`=1 at an edge, overrides everything): shadow and active = RESET_VAL; dirty = 0; `rd_data` = 0; `commit_done` = 0; `wr_err` = 0.
- Write: `wr_en` && `wr_addr < NREGS` → enabled bytes of `shadow[wr_addr]` take `wr_data`, other bytes hold; `dirty[wr_addr]` set iff `wr_be != 0`. `wr_be = 0` is a no-op (no error).
- Out-of-range write: `wr_en` && `wr_addr ≥ NREGS` → no state change; `wr_err` = 1 for the following cycle.
- Commit: for every i with `dirty[i]`, `active[i] <= shadow[i]`; all dirty bits cleared; `commit_done` = 1 for the following cycle (also when nothing was dirty).
- Write + commit in the same cycle: the write is merged into the commit. The active copy receives the post-write value, and that register ends up clean.
- Discard: `shadow[i] <= active[i]` for all i; dirty cleared. A same-cycle write is dropped, but `wr_err` still reports an out-of-range write.
- Commit + discard in the same cycle: commit wins, discard is ignored.
- Read: `rd_data <=` selected copy at `rd_addr`, using the pre-edge contents; out-of-range `rd_addr` → 0.
- `active_flat` and `dirty_any` are driven directly from registers (no combinational input path).

## Timing
- Write at edge k: visible in shadow after k; readable via `rd_sel`=1 in `rd_data` after edge k+1.
- Commit at edge k: `active_flat` updated after k; `commit_done` high for cycle k..k+1; `rd_data` (`rd_sel`=0) shows the new value after edge k+1.
- Read latency: exactly 1 cycle from `rd_addr`/`rd_sel` to `rd_data`; a new read may be issued every cycle.
- `dirty_any` rises in the cycle after the first effective write. It falls in the cycle after commit or discard.
- Reset mid-sequence: pending dirty data is lost; `commit_done`/`wr_err` pulses in flight are cleared.

## Test plan
Configuration: WIDTH=32, NREGS=3, RESET_VAL=32'h0000_00FF.
1. Reset, then read regs 0–2 with each `rd_sel` value → every read = 32'h0000_00FF; `dirty_any`=0; `active_flat` = 3×32'h0000_00FF.
2. Write reg1 = 32'hA5A5_A5A5 with `wr_be`=4'b1111, then reg1 = 32'h1234_5678 with `wr_be`=4'b0101 → shadow reg1 = 32'hA534_A578; active reg1 still 32'h0000_00FF; `dirty_any`=1. Commit → active reg1 = 32'hA534_A578; `commit_done` pulses once; `dirty_any`=0.
3. Write reg2 = 32'hDEAD_BEEF, then discard → shadow reg2 = 32'h0000_00FF; active is unchanged; `dirty_any`=0; no `commit_done`.
4. Same-cycle write reg0 = 32'hCAFE_F00D (all bytes) plus commit → active reg0 = 32'hCAFE_F00D the next cycle; dirty clear. Commit + discard with reg2 dirty → commit wins and reg2 becomes active.
5. Write to `wr_addr`=3 → `wr_err` pulses for 1 cycle; all registers unchanged. Read `rd_addr`=3 → `rd_data` = 0.
6. Dirty reg1, then assert `rst` for 1 cycle during a commit → all registers = 32'h0000_00FF; `commit_done`=0; `dirty_any`=0.

Source files
------------

// File: rtl/reg_bank_shadow_if.sv
// Software-side bus for the shadowed register bank: write port, commit/discard
// controls, a registered read port and the flattened active configuration.
interface reg_bank_shadow_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 4
);
  localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic [WIDTH/8-1:0]     wr_be;
  logic                   commit;
  logic                   discard;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   rd_sel;
  logic [WIDTH-1:0]       rd_data;
  logic [NREGS*WIDTH-1:0] active_flat;
  logic                   dirty_any;
  logic                   commit_done;
  logic                   wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, commit, discard, rd_addr, rd_sel,
    input  rd_data, active_flat, dirty_any, commit_done, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, commit, discard, rd_addr, rd_sel,
    output rd_data, active_flat, dirty_any, commit_done, wr_err
  );
endinterface

// File: rtl/reg_bank_shadow.sv
// Double-buffered register bank: byte-masked writes land in a shadow copy,
// commit moves dirty shadows to the active copy atomically, discard reverts.

// One register: shadow/active pair plus its dirty bit.
module reg_bank_shadow_lane #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH-1:0]   data,
  input  logic               commit,
  input  logic               discard,
  output logic [WIDTH-1:0]   shadow,
  output logic [WIDTH-1:0]   active,
  output logic               dirty
);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] merged;
  logic             wr_eff;

  // Shadow value with this cycle's enabled bytes applied.
  always_comb begin
    merged = shadow;
    for (int b = 0; b < NB; b++)
      if (wr && be[b]) merged[8*b +: 8] = data[8*b +: 8];
  end

  assign wr_eff = wr && (|be);

  // Commit beats discard beats plain write; a write in a commit cycle is merged.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= RESET_VAL;
      active <= RESET_VAL;
      dirty  <= 1'b0;
    end else if (commit) begin
      shadow <= merged;
      if (dirty || wr_eff) active <= merged;
      dirty  <= 1'b0;
    end else if (discard) begin
      shadow <= active;
      dirty  <= 1'b0;
    end else if (wr) begin
      shadow <= merged;
      if (wr_eff) dirty <= 1'b1;
    end
  end
endmodule

module reg_bank_shadow #(
  parameter int               WIDTH     = 32,
  parameter int               NREGS     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  reg_bank_shadow_if.slave bus
);
  localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [NREGS-1:0][WIDTH-1:0] shadow;
  logic [NREGS-1:0][WIDTH-1:0] active;
  logic [NREGS-1:0]            dirty;
  logic [WIDTH-1:0]            rd_next;
  logic [WIDTH-1:0]            rd_q;
  logic                        commit_q;
  logic                        err_q;
  logic                        wr_oob;

  assign wr_oob = bus.wr_en && ({1'b0, bus.wr_addr} >= (ADDR_W+1)'(NREGS));

  genvar i;
  generate
    for (i = 0; i < NREGS; i++) begin : g_reg
      reg_bank_shadow_lane #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_lane (
        .clk    (clk),
        .rst    (rst),
        .wr     (bus.wr_en && (bus.wr_addr == ADDR_W'(i))),
        .be     (bus.wr_be),
        .data   (bus.wr_data),
        .commit (bus.commit),
        .discard(bus.discard),
        .shadow (shadow[i]),
        .active (active[i]),
        .dirty  (dirty[i])
      );
    end
  endgenerate

  // Read mux over pre-edge contents; unmatched (out-of-range) index reads 0.
  always_comb begin
    rd_next = '0;
    for (int r = 0; r < NREGS; r++)
      if (bus.rd_addr == ADDR_W'(r)) rd_next = bus.rd_sel ? shadow[r] : active[r];
  end

  // Registered read data and the single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q     <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_q     <= rd_next;
      commit_q <= bus.commit;
      err_q    <= wr_oob;
    end
  end

  assign bus.rd_data     = rd_q;
  assign bus.active_flat = active;
  assign bus.dirty_any   = |dirty;
  assign bus.commit_done = commit_q;
  assign bus.wr_err      = err_q;
endmodule

// File: tb/tb_reg_bank_shadow.sv
// Directed bench: reads go through an expected-value queue checked by a
// monitor when read data becomes valid; status outputs checked inline.
module tb_reg_bank_shadow;
  localparam int          W  = 32;
  localparam int          N  = 3;
  localparam logic [31:0] RV = 32'h0000_00FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bank_shadow_if #(.WIDTH(W), .NREGS(N)) bus ();

  reg_bank_shadow #(.WIDTH(W), .NREGS(N), .RESET_VAL(RV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int passed = 0;
  int total  = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_req = 1'b0;
  logic        rd_vld = 1'b0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Read issued at an edge has data valid after that edge.
  always @(posedge clk) rd_vld <= rd_req;

  // Monitor: pop and compare whenever read data is valid.
  always @(negedge clk) begin
    if (rd_vld) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_unexpected: got %h expected nothing queued", bus.rd_data);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string       n = name_q.pop_front();
        if (bus.rd_data === e) passed++;
        else $display("FAIL %s: got %h expected %h", n, bus.rd_data, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic sel, input logic [31:0] e, input string n);
    bus.rd_addr = a;
    bus.rd_sel  = sel;
    rd_req      = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
    step();
    rd_req = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_be   = be;
    step();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_be   = '0;
    bus.commit  = 1'b0;
    bus.discard = 1'b0;
    bus.rd_addr = '0;
    bus.rd_sel  = 1'b0;

    // 1. reset state
    step(); step();
    rst = 1'b0;
    chk("rst_rd_data", {64'd0, bus.rd_data}, {64'd0, 32'd0});
    chk("rst_dirty", {95'd0, bus.dirty_any}, 96'd0);
    chk("rst_active_flat", bus.active_flat, {RV, RV, RV});
    chk("rst_commit_done", {95'd0, bus.commit_done}, 96'd0);
    chk("rst_wr_err", {95'd0, bus.wr_err}, 96'd0);
    for (int a = 0; a < 3; a++)
      for (int s = 0; s < 2; s++)
        rd(2'(a), 1'(s), RV, $sformatf("rst_rd_r%0d_s%0d", a, s));

    // 2. byte-masked writes, then commit
    wr(2'd1, 32'hA5A5_A5A5, 4'b1111);
    wr(2'd1, 32'h1234_5678, 4'b0101);
    chk("t2_dirty", {95'd0, bus.dirty_any}, 96'd1);
    rd(2'd1, 1'b1, 32'hA534_A578, "t2_shadow_r1");
    rd(2'd1, 1'b0, RV, "t2_active_r1_pre");
    chk("t2_active_pre", {64'd0, bus.active_flat[63:32]}, {64'd0, RV});
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("t2_active_post", {64'd0, bus.active_flat[63:32]}, {64'd0, 32'hA534_A578});
    chk("t2_commit_done", {95'd0, bus.commit_done}, 96'd1);
    chk("t2_dirty_clr", {95'd0, bus.dirty_any}, 96'd0);
    step();
    chk("t2_commit_done_once", {95'd0, bus.commit_done}, 96'd0);
    rd(2'd1, 1'b0, 32'hA534_A578, "t2_active_r1_rd");

    // 3. write then discard
    wr(2'd2, 32'hDEAD_BEEF, 4'b1111);
    rd(2'd2, 1'b1, 32'hDEAD_BEEF, "t3_shadow_r2_pre");
    bus.discard = 1'b1;
    step();
    bus.discard = 1'b0;
    chk("t3_dirty", {95'd0, bus.dirty_any}, 96'd0);
    chk("t3_no_commit_done", {95'd0, bus.commit_done}, 96'd0);
    chk("t3_active", bus.active_flat, {RV, 32'hA534_A578, RV});
    rd(2'd2, 1'b1, RV, "t3_shadow_r2_post");

    // 4. write merged with commit; commit beats discard
    bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 32'hCAFE_F00D; bus.wr_be = 4'hF;
    bus.commit = 1'b1;
    step();
    bus.wr_en = 1'b0; bus.commit = 1'b0;
    chk("t4_active_r0", {64'd0, bus.active_flat[31:0]}, {64'd0, 32'hCAFE_F00D});
    chk("t4_dirty", {95'd0, bus.dirty_any}, 96'd0);
    chk("t4_commit_done", {95'd0, bus.commit_done}, 96'd1);
    wr(2'd2, 32'h1122_3344, 4'b1111);
    bus.commit = 1'b1; bus.discard = 1'b1;
    step();
    bus.commit = 1'b0; bus.discard = 1'b0;
    chk("t4_commit_wins", bus.active_flat, {32'h1122_3344, 32'hA534_A578, 32'hCAFE_F00D});
    chk("t4_dirty2", {95'd0, bus.dirty_any}, 96'd0);
    rd(2'd2, 1'b1, 32'h1122_3344, "t4_shadow_r2");

    // 5. out-of-range write/read, zero byte-enable write
    wr(2'd3, 32'h5555_5555, 4'b1111);
    chk("t5_wr_err", {95'd0, bus.wr_err}, 96'd1);
    chk("t5_oob_dirty", {95'd0, bus.dirty_any}, 96'd0);
    step();
    chk("t5_wr_err_once", {95'd0, bus.wr_err}, 96'd0);
    chk("t5_unchanged", bus.active_flat, {32'h1122_3344, 32'hA534_A578, 32'hCAFE_F00D});
    rd(2'd3, 1'b0, 32'd0, "t5_oob_rd_active");
    rd(2'd3, 1'b1, 32'd0, "t5_oob_rd_shadow");
    rd(2'd0, 1'b1, 32'hCAFE_F00D, "t5_shadow_r0");
    wr(2'd0, 32'h0BAD_0BAD, 4'b0000);
    chk("t5_be0_dirty", {95'd0, bus.dirty_any}, 96'd0);
    chk("t5_be0_wr_err", {95'd0, bus.wr_err}, 96'd0);
    rd(2'd0, 1'b1, 32'hCAFE_F00D, "t5_be0_shadow_r0");

    // 6. reset during a commit
    wr(2'd1, 32'hFFFF_0000, 4'b1111);
    chk("t6_dirty", {95'd0, bus.dirty_any}, 96'd1);
    bus.commit = 1'b1; rst = 1'b1;
    step();
    bus.commit = 1'b0; rst = 1'b0;
    chk("t6_active", bus.active_flat, {RV, RV, RV});
    chk("t6_commit_done", {95'd0, bus.commit_done}, 96'd0);
    chk("t6_dirty_clr", {95'd0, bus.dirty_any}, 96'd0);
    rd(2'd1, 1'b1, RV, "t6_shadow_r1");
    rd(2'd0, 1'b0, RV, "t6_active_r0");

    // drain the scoreboard, bounded
    for (int c = 0; c < 10 && (exp_q.size() != 0 || rd_vld); c++) step();
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d reads outstanding expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
